// File: rtl/apb2axi_pkg.sv
// Shared completion types for the APB-to-AXI bridge: completion entry layout and
// completion source encoding used by the completion arbiter.
package apb2axi_pkg;

   localparam int unsigned TAG_W = 4;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic             is_write;
      logic             error;
      logic [15:0]      data;
   } completion_entry_t;

   localparam int unsigned COMPLETION_W = $bits(completion_entry_t);

   typedef enum logic {
      CPL_SRC_RD = 1'b0,
      CPL_SRC_WR = 1'b1
   } cpl_src_e;

   typedef enum logic {
      SlotEmpty = 1'b0,
      SlotFull  = 1'b1
   } slot_state_e;

endpackage

// File: rtl/apb2axi_cpl_fifo.sv
// Small synchronous FIFO holding completions from one source; head is visible
// combinationally so the arbiter can inspect it before popping.
module apb2axi_cpl_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned W     = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH) + 1;

   logic [W-1:0]    mem_q [DEPTH];
   logic [W-1:0]    mem_d [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = (count_q == CntW'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/apb2axi_cpl_arbiter.sv
// Merges read and write completions into one registered stream via round-robin.
// Define APB2AXI_CPL_ERR_PRIO_EN to let an erroring head win over a clean one.
module apb2axi_cpl_arbiter
   import apb2axi_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                          pclk,
   input  logic                          presetn,
   input  logic                          rd_cpl_valid,
   input  logic [COMPLETION_W-1:0]       rd_cpl_data,
   output logic                          rd_cpl_ready,
   input  logic                          wr_cpl_valid,
   input  logic [COMPLETION_W-1:0]       wr_cpl_data,
   output logic                          wr_cpl_ready,
   output logic                          gw_cpl_valid,
   output logic [COMPLETION_W-1:0]       gw_cpl_data,
   input  logic                          gw_cpl_ready,
   output logic [$clog2(FIFO_DEPTH):0]   rd_fifo_count,
   output logic [$clog2(FIFO_DEPTH):0]   wr_fifo_count,
   output logic                          last_grant
);

   logic                    rd_push, rd_pop, rd_full, rd_empty;
   logic                    wr_push, wr_pop, wr_full, wr_empty;
   logic [COMPLETION_W-1:0] rd_head, wr_head;
   logic                    slot_free, load;
   cpl_src_e                grant;

   slot_state_e             slot_q, slot_d;
   logic [COMPLETION_W-1:0] gw_data_q, gw_data_d;
   cpl_src_e                last_grant_q, last_grant_d;

   // Readiness comes only from registered occupancy, never from the gateway side.
   assign rd_cpl_ready = !rd_full;
   assign wr_cpl_ready = !wr_full;
   assign rd_push      = rd_cpl_valid && rd_cpl_ready;
   assign wr_push      = wr_cpl_valid && wr_cpl_ready;

   apb2axi_cpl_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (COMPLETION_W)
   ) u_rd_fifo (
      .clk   (pclk),
      .rst_n (presetn),
      .push  (rd_push),
      .pop   (rd_pop),
      .din   (rd_cpl_data),
      .head  (rd_head),
      .count (rd_fifo_count),
      .full  (rd_full),
      .empty (rd_empty)
   );

   apb2axi_cpl_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (COMPLETION_W)
   ) u_wr_fifo (
      .clk   (pclk),
      .rst_n (presetn),
      .push  (wr_push),
      .pop   (wr_pop),
      .din   (wr_cpl_data),
      .head  (wr_head),
      .count (wr_fifo_count),
      .full  (wr_full),
      .empty (wr_empty)
   );

`ifdef APB2AXI_CPL_ERR_PRIO_EN
   completion_entry_t rd_entry, wr_entry;
   assign rd_entry = rd_head;
   assign wr_entry = wr_head;
`endif

   always_comb begin
      grant = CPL_SRC_RD;
      if (rd_empty) begin
         grant = CPL_SRC_WR;
      end else if (wr_empty) begin
         grant = CPL_SRC_RD;
`ifdef APB2AXI_CPL_ERR_PRIO_EN
      end else if (rd_entry.error != wr_entry.error) begin
         grant = wr_entry.error ? CPL_SRC_WR : CPL_SRC_RD;
`endif
      end else begin
         grant = (last_grant_q == CPL_SRC_RD) ? CPL_SRC_WR : CPL_SRC_RD;
      end
   end

   assign slot_free = !gw_cpl_valid || gw_cpl_ready;
   assign load      = slot_free && !(rd_empty && wr_empty);
   assign rd_pop    = load && (grant == CPL_SRC_RD);
   assign wr_pop    = load && (grant == CPL_SRC_WR);

   // Output slot: state register.
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         slot_q       <= SlotEmpty;
         gw_data_q    <= '0;
         last_grant_q <= CPL_SRC_WR;
      end else begin
         slot_q       <= slot_d;
         gw_data_q    <= gw_data_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Output slot: next state. Data is held whenever nothing is loaded.
   always_comb begin
      slot_d       = slot_q;
      gw_data_d    = gw_data_q;
      last_grant_d = last_grant_q;
      if (slot_free) begin
         slot_d = load ? SlotFull : SlotEmpty;
      end
      if (load) begin
         gw_data_d    = (grant == CPL_SRC_WR) ? wr_head : rd_head;
         last_grant_d = grant;
      end
   end

   // Output slot: outputs.
   always_comb begin
      gw_cpl_valid = (slot_q == SlotFull);
      gw_cpl_data  = gw_data_q;
      last_grant   = last_grant_q;
   end

endmodule

// File: tb/tb_apb2axi_cpl_arbiter.sv
// Directed and randomized bench for apb2axi_cpl_arbiter; the random phase is checked
// against a queue-based model of the merge rules (honours APB2AXI_CPL_ERR_PRIO_EN).
module tb_apb2axi_cpl_arbiter;
   import apb2axi_pkg::*;

   localparam int unsigned Depth = 2;

   logic                    pclk = 1'b0;
   logic                    presetn = 1'b0;
   logic                    rd_cpl_valid = 1'b0;
   logic [COMPLETION_W-1:0] rd_cpl_data = '0;
   logic                    rd_cpl_ready;
   logic                    wr_cpl_valid = 1'b0;
   logic [COMPLETION_W-1:0] wr_cpl_data = '0;
   logic                    wr_cpl_ready;
   logic                    gw_cpl_valid;
   logic [COMPLETION_W-1:0] gw_cpl_data;
   logic                    gw_cpl_ready = 1'b1;
   logic [$clog2(Depth):0]  rd_fifo_count;
   logic [$clog2(Depth):0]  wr_fifo_count;
   logic                    last_grant;

   int errors = 0;
   int checks = 0;

   apb2axi_cpl_arbiter #(
      .FIFO_DEPTH (Depth)
   ) dut (
      .pclk          (pclk),
      .presetn       (presetn),
      .rd_cpl_valid  (rd_cpl_valid),
      .rd_cpl_data   (rd_cpl_data),
      .rd_cpl_ready  (rd_cpl_ready),
      .wr_cpl_valid  (wr_cpl_valid),
      .wr_cpl_data   (wr_cpl_data),
      .wr_cpl_ready  (wr_cpl_ready),
      .gw_cpl_valid  (gw_cpl_valid),
      .gw_cpl_data   (gw_cpl_data),
      .gw_cpl_ready  (gw_cpl_ready),
      .rd_fifo_count (rd_fifo_count),
      .wr_fifo_count (wr_fifo_count),
      .last_grant    (last_grant)
   );

   always #5 pclk = ~pclk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic do_reset();
      presetn      = 1'b0;
      rd_cpl_valid = 1'b0;
      wr_cpl_valid = 1'b0;
      tick();
      presetn = 1'b1;
   endtask

   function automatic logic [COMPLETION_W-1:0] mk(input int tag, input bit wr, input bit err,
                                                  input int pl);
      completion_entry_t e;
      e.tag      = tag[TAG_W-1:0];
      e.is_write = wr;
      e.error    = err;
      e.data     = pl[15:0];
      return e;
   endfunction

   function automatic int tag_of(input logic [COMPLETION_W-1:0] d);
      completion_entry_t e;
      e = d;
      return int'(e.tag);
   endfunction

   function automatic bit isw_of(input logic [COMPLETION_W-1:0] d);
      completion_entry_t e;
      e = d;
      return e.is_write;
   endfunction

   function automatic bit err_of(input logic [COMPLETION_W-1:0] d);
      completion_entry_t e;
      e = d;
      return e.error;
   endfunction

   logic [COMPLETION_W-1:0] rq[$];
   logic [COMPLETION_W-1:0] wq[$];
   bit                      mv;
   logic [COMPLETION_W-1:0] md;
   bit                      ml;

   initial begin
      int next_tag;
      int exp_tag;
      bit accepted;
      bit rpush, wpush, pick_wr;

      // Reset state
      gw_cpl_ready = 1'b1;
      do_reset();
      check("rst_valid", gw_cpl_valid, 0);
      check("rst_data", gw_cpl_data, 0);
      check("rst_rd_cnt", rd_fifo_count, 0);
      check("rst_wr_cnt", wr_fifo_count, 0);
      check("rst_last_grant", last_grant, 1);
      check("rst_rd_ready", rd_cpl_ready, 1);
      check("rst_wr_ready", wr_cpl_ready, 1);

      // Single read completion latency
      rd_cpl_data  = mk(3, 0, 0, 16'h1234);
      rd_cpl_valid = 1'b1;
      tick();
      rd_cpl_valid = 1'b0;
      check("t1_valid_at_push", gw_cpl_valid, 0);
      check("t1_rd_cnt", rd_fifo_count, 1);
      tick();
      check("t1_valid", gw_cpl_valid, 1);
      check("t1_tag", tag_of(gw_cpl_data), 3);
      check("t1_is_write", isw_of(gw_cpl_data), 0);
      check("t1_data", gw_cpl_data, mk(3, 0, 0, 16'h1234));
      check("t1_last_grant", last_grant, 0);
      tick();
      check("t1_drained", gw_cpl_valid, 0);

      // Simultaneous rd/wr after reset: rd wins first tie
      do_reset();
      rd_cpl_data  = mk(1, 0, 0, 16'h0011);
      wr_cpl_data  = mk(2, 1, 0, 16'h0022);
      rd_cpl_valid = 1'b1;
      wr_cpl_valid = 1'b1;
      tick();
      rd_cpl_valid = 1'b0;
      wr_cpl_valid = 1'b0;
      tick();
      check("t2_tag0", tag_of(gw_cpl_data), 1);
      check("t2_lg0", last_grant, 0);
      tick();
      check("t2_tag1", tag_of(gw_cpl_data), 2);
      check("t2_isw1", isw_of(gw_cpl_data), 1);
      check("t2_lg1", last_grant, 1);
      tick();
      check("t2_drained", gw_cpl_valid, 0);

      // Backpressure: fill both FIFOs behind a held output slot
      gw_cpl_ready = 1'b0;
      rd_cpl_data  = mk(4, 0, 0, 16'h0044);
      wr_cpl_data  = mk(5, 1, 0, 16'h0055);
      rd_cpl_valid = 1'b1;
      wr_cpl_valid = 1'b1;
      tick();
      rd_cpl_data = mk(6, 0, 0, 16'h0066);
      wr_cpl_data = mk(7, 1, 0, 16'h0077);
      tick();
      rd_cpl_data  = mk(8, 0, 0, 16'h0088);
      wr_cpl_valid = 1'b0;
      tick();
      check("t3_rd_ready", rd_cpl_ready, 0);
      check("t3_wr_ready", wr_cpl_ready, 0);
      check("t3_rd_cnt", rd_fifo_count, 2);
      check("t3_wr_cnt", wr_fifo_count, 2);
      rd_cpl_data  = mk(9, 0, 0, 16'h0099);
      wr_cpl_data  = mk(10, 1, 0, 16'h00aa);
      wr_cpl_valid = 1'b1;
      tick();
      rd_cpl_valid = 1'b0;
      wr_cpl_valid = 1'b0;
      check("t3_rd_cnt_full", rd_fifo_count, 2);
      check("t3_wr_cnt_full", wr_fifo_count, 2);
      check("t3_hold_valid", gw_cpl_valid, 1);
      check("t3_hold_data", gw_cpl_data, mk(4, 0, 0, 16'h0044));
      tick();
      check("t3_hold_data2", gw_cpl_data, mk(4, 0, 0, 16'h0044));
      gw_cpl_ready = 1'b1;
      for (int i = 5; i <= 8; i++) begin
         tick();
         check($sformatf("t3_order_%0d", i), tag_of(gw_cpl_data), i);
         check($sformatf("t3_isw_%0d", i), isw_of(gw_cpl_data), (i % 2 == 1) ? 1 : 0);
      end
      tick();
      check("t3_drained", gw_cpl_valid, 0);

      // Full rd FIFO streaming with simultaneous push and pop
      do_reset();
      gw_cpl_ready = 1'b0;
      rd_cpl_valid = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         rd_cpl_data = mk(i, 0, 0, i * 3);
         tick();
      end
      rd_cpl_valid = 1'b0;
      check("t4_full_cnt", rd_fifo_count, 2);
      check("t4_full_ready", rd_cpl_ready, 0);
      gw_cpl_ready = 1'b1;
      next_tag = 4;
      exp_tag  = 1;
      for (int i = 0; i < 10; i++) begin
         rd_cpl_valid = 1'b1;
         rd_cpl_data  = mk(next_tag, 0, 0, next_tag * 3);
         check("t4_stream_valid", gw_cpl_valid, 1);
         check("t4_stream_tag", tag_of(gw_cpl_data), exp_tag);
         exp_tag++;
         accepted = rd_cpl_ready;
         tick();
         if (accepted) next_tag++;
         check("t4_stream_cnt", rd_fifo_count, 1);
      end
      rd_cpl_valid = 1'b0;
      for (int k = 0; k < 4 && exp_tag < next_tag; k++) begin
         check("t4_drain_valid", gw_cpl_valid, 1);
         check("t4_drain_tag", tag_of(gw_cpl_data), exp_tag);
         exp_tag++;
         tick();
      end
      check("t4_all_out", exp_tag, next_tag);
      check("t4_empty", gw_cpl_valid, 0);

      // Error priority against round-robin
      do_reset();
      gw_cpl_ready = 1'b0;
      rd_cpl_data  = mk(1, 0, 0, 16'h0101);
      wr_cpl_data  = mk(2, 1, 1, 16'h0202);
      rd_cpl_valid = 1'b1;
      wr_cpl_valid = 1'b1;
      tick();
      rd_cpl_valid = 1'b0;
      wr_cpl_valid = 1'b0;
      tick();
`ifdef APB2AXI_CPL_ERR_PRIO_EN
      check("t5_first_tag", tag_of(gw_cpl_data), 2);
      check("t5_first_lg", last_grant, 1);
`else
      check("t5_first_tag", tag_of(gw_cpl_data), 1);
      check("t5_first_lg", last_grant, 0);
`endif
      gw_cpl_ready = 1'b1;
      tick();
`ifdef APB2AXI_CPL_ERR_PRIO_EN
      check("t5_second_tag", tag_of(gw_cpl_data), 1);
      check("t5_second_lg", last_grant, 0);
`else
      check("t5_second_tag", tag_of(gw_cpl_data), 2);
      check("t5_second_lg", last_grant, 1);
`endif

      // Mid-burst reset
      do_reset();
      gw_cpl_ready = 1'b0;
      rd_cpl_data  = mk(1, 0, 0, 1);
      wr_cpl_data  = mk(2, 1, 0, 2);
      rd_cpl_valid = 1'b1;
      wr_cpl_valid = 1'b1;
      tick();
      rd_cpl_data = mk(3, 0, 0, 3);
      wr_cpl_data = mk(4, 1, 0, 4);
      tick();
      check("t6_pre_valid", gw_cpl_valid, 1);
      do_reset();
      check("t6_valid", gw_cpl_valid, 0);
      check("t6_data", gw_cpl_data, 0);
      check("t6_rd_cnt", rd_fifo_count, 0);
      check("t6_wr_cnt", wr_fifo_count, 0);
      check("t6_lg", last_grant, 1);
      check("t6_rd_ready", rd_cpl_ready, 1);
      gw_cpl_ready = 1'b1;
      tick();
      check("t6_stays_empty", gw_cpl_valid, 0);

      // Randomized traffic against the queue model
      do_reset();
      rq.delete();
      wq.delete();
      mv = 1'b0;
      md = '0;
      ml = 1'b1;
      for (int cyc = 0; cyc < 600; cyc++) begin
         rd_cpl_valid = 1'($urandom_range(0, 1));
         wr_cpl_valid = 1'($urandom_range(0, 1));
         gw_cpl_ready = ($urandom_range(0, 3) != 0);
         rd_cpl_data  = mk($urandom_range(0, 15), 0, 1'($urandom_range(0, 1)), $urandom);
         wr_cpl_data  = mk($urandom_range(0, 15), 1, 1'($urandom_range(0, 1)), $urandom);

         check("rnd_valid", gw_cpl_valid, mv);
         if (mv) check("rnd_data", gw_cpl_data, md);
         check("rnd_lg", last_grant, ml);
         check("rnd_rd_cnt", rd_fifo_count, rq.size());
         check("rnd_wr_cnt", wr_fifo_count, wq.size());
         check("rnd_rd_ready", rd_cpl_ready, rq.size() < Depth);
         check("rnd_wr_ready", wr_cpl_ready, wq.size() < Depth);

         rpush = rd_cpl_valid && (rq.size() < Depth);
         wpush = wr_cpl_valid && (wq.size() < Depth);
         if (!mv || gw_cpl_ready) begin
            if (rq.size() > 0 || wq.size() > 0) begin
               if (rq.size() == 0) pick_wr = 1'b1;
               else if (wq.size() == 0) pick_wr = 1'b0;
`ifdef APB2AXI_CPL_ERR_PRIO_EN
               else if (err_of(rq[0]) != err_of(wq[0])) pick_wr = err_of(wq[0]);
`endif
               else pick_wr = !ml;
               md = pick_wr ? wq.pop_front() : rq.pop_front();
               mv = 1'b1;
               ml = pick_wr;
            end else begin
               mv = 1'b0;
            end
         end
         if (rpush) rq.push_back(rd_cpl_data);
         if (wpush) wq.push_back(wr_cpl_data);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
